// File: rtl/err_report_sched.sv
// Round-robin error-update scheduler with holdoff and clear-all sequencing.
// Optional per-channel rise counters are enabled by defining ERR_SCHED_CNT_EN.
module err_report_sched #(
    parameter int NCH     = 18,
    parameter int HOLDOFF = 4,
    parameter int HW      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          err_raw,
    input  logic [NCH-1:0]          chan_en,
    input  logic                    clear_req,
    output logic [NCH-1:0]          err_val,
    output logic [NCH-1:0]          send_err,
    output logic                    busy
`ifdef ERR_SCHED_CNT_EN
    ,
    input  logic [$clog2(NCH)-1:0]  cnt_sel,
    output logic [7:0]              cnt_out
`endif
);

    localparam int PW = $clog2(NCH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CLEAR,
        S_HOLD
    } state_t;

    state_t          state_q;
    logic [NCH-1:0]  pend_q;
    logic [NCH-1:0]  rep_q;
    logic [NCH-1:0]  rep_d;
    logic [NCH-1:0]  err_val_q;
    logic [NCH-1:0]  send_err_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   w_q;
    logic [HW-1:0]   hold_q;
    logic            clr_pend_q;

    logic            win_any;
    logic            hi_found;
    logic [PW-1:0]   hi_idx;
    logic [PW-1:0]   lo_idx;
    logic [PW-1:0]   win_idx;
    logic            upd;

    // Descending scan: the last hit is the lowest index at/above ptr
    always_comb begin
        win_any  = 1'b0;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                win_any = 1'b1;
                lo_idx  = PW'(i);
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    // A winner whose mismatch vanished before ISSUE is dropped silently
    assign upd = chan_en[w_q] & (err_raw[w_q] ^ rep_q[w_q]);

    always_comb begin
        rep_d = rep_q;
        if (state_q == S_ISSUE && upd) begin
            rep_d[w_q] = err_raw[w_q];
        end else if (state_q == S_CLEAR) begin
            rep_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pend_q     <= '0;
            rep_q      <= '0;
            err_val_q  <= '0;
            send_err_q <= '0;
            ptr_q      <= '0;
            w_q        <= '0;
            hold_q     <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            pend_q     <= chan_en & (err_raw ^ rep_d);
            rep_q      <= rep_d;
            send_err_q <= '0;
            if (clear_req) begin
                clr_pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (clr_pend_q) begin
                        state_q <= S_CLEAR;
                        if (!clear_req) begin
                            clr_pend_q <= 1'b0;
                        end
                    end else if (win_any) begin
                        w_q     <= win_idx;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (upd) begin
                        send_err_q     <= NCH'(1) << w_q;
                        err_val_q[w_q] <= err_raw[w_q];
                        ptr_q <= (w_q == PW'(NCH - 1)) ? '0 : w_q + 1'b1;
                        if (HOLDOFF > 0) begin
                            state_q <= S_HOLD;
                            hold_q  <= HW'(HOLDOFF);
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    send_err_q <= '1;
                    err_val_q  <= '0;
                    if (HOLDOFF > 0) begin
                        state_q <= S_HOLD;
                        hold_q  <= HW'(HOLDOFF);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    hold_q <= hold_q - 1'b1;
                    if (hold_q == HW'(1)) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign err_val  = err_val_q;
    assign send_err = send_err_q;
    assign busy     = (state_q != S_IDLE);

`ifdef ERR_SCHED_CNT_EN
    logic [7:0] cnt_q [NCH];
    logic [7:0] cnt_out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            cnt_out_q <= '0;
        end else begin
            if (state_q == S_CLEAR) begin
                for (int i = 0; i < NCH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else if (state_q == S_ISSUE && upd && err_raw[w_q]
                         && !rep_q[w_q] && cnt_q[w_q] != 8'hFF) begin
                cnt_q[w_q] <= cnt_q[w_q] + 8'd1;
            end
            cnt_out_q <= (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
        end
    end

    assign cnt_out = cnt_out_q;
`endif

endmodule

// File: tb/tb_err_report_sched.sv
// Directed self-checking bench for err_report_sched (NCH=18, HOLDOFF=4).
// Counter checks run only when ERR_SCHED_CNT_EN is defined.
module tb_err_report_sched;

    localparam int NCH = 18;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH-1:0]  err_raw;
    logic [NCH-1:0]  chan_en;
    logic            clear_req;
    logic [NCH-1:0]  err_val;
    logic [NCH-1:0]  send_err;
    logic            busy;
`ifdef ERR_SCHED_CNT_EN
    logic [4:0]      cnt_sel;
    logic [7:0]      cnt_out;
`endif

    int nvec = 0;
    int nerr = 0;

    err_report_sched #(
        .NCH(NCH),
        .HOLDOFF(4),
        .HW(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .err_raw(err_raw),
        .chan_en(chan_en),
        .clear_req(clear_req),
        .err_val(err_val),
        .send_err(send_err),
        .busy(busy)
`ifdef ERR_SCHED_CNT_EN
        ,
        .cnt_sel(cnt_sel),
        .cnt_out(cnt_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_send(input int lim, output logic [NCH-1:0] s,
                             output int n);
        s = '0;
        n = 0;
        while (n < lim) begin
            tick();
            n++;
            if (send_err !== '0) begin
                s = send_err;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        err_raw   = '0;
        chan_en   = '1;
        clear_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int nb;
        reset     = 1'b0;
        err_raw   = 18'h00004;
        chan_en   = '1;
        clear_req = 1'b0;
        tick();
        tick();
        nvec++;
        if (send_err !== '0 || err_val !== '0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_outs: got send=%h val=%h busy=%b want 0",
                     send_err, err_val, busy);
        end
        reset = 1'b1;
        tick();
        tick();
        nvec++;
        if (send_err !== '0 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL rst_edge2: got send=%h busy=%b want 0/1",
                     send_err, busy);
        end
        tick();
        nvec++;
        if (send_err !== 18'h00004 || err_val !== 18'h00004) begin
            nerr++;
            $display("FAIL rst_edge3: got send=%h val=%h want 00004/00004",
                     send_err, err_val);
        end
        nb = 2;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy === 1'b1) nb++;
            nvec++;
            if (send_err !== '0) begin
                nerr++;
                $display("FAIL rst_quiet: got send=%h want 0", send_err);
            end
        end
        nvec++;
        if (nb != 5) begin
            nerr++;
            $display("FAIL rst_busy_len: got %0d want 5", nb);
        end
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] s;
        int n;
        apply_reset();
        err_raw = 18'h20021;
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h00001 || n != 3) begin
            nerr++;
            $display("FAIL rr_first: got %h after %0d want 00001 after 3", s, n);
        end
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h00020 || n != 6) begin
            nerr++;
            $display("FAIL rr_second: got %h after %0d want 00020 after 6", s, n);
        end
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h20000 || n != 6) begin
            nerr++;
            $display("FAIL rr_third: got %h after %0d want 20000 after 6", s, n);
        end
        nvec++;
        if (err_val !== 18'h20021) begin
            nerr++;
            $display("FAIL rr_val: got %h want 20021", err_val);
        end
        err_raw = 18'h20021 ^ 18'h10001;
        wait_send(12, s, n);
        nvec++;
        if (s !== 18'h00001 || err_val !== 18'h20020) begin
            nerr++;
            $display("FAIL rr_wrap_a: got %h val=%h want 00001 val=20020",
                     s, err_val);
        end
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h10000 || err_val !== 18'h30020) begin
            nerr++;
            $display("FAIL rr_wrap_b: got %h val=%h want 10000 val=30020",
                     s, err_val);
        end
    endtask

    task automatic test_glitch();
        logic [NCH-1:0] s;
        int n;
        int ns;
        apply_reset();
        err_raw = 18'h00400;
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h00400) begin
            nerr++;
            $display("FAIL gl_setup: got %h want 00400", s);
        end
        err_raw[3] = 1'b1;
        tick();
        err_raw[3] = 1'b0;
        ns = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (send_err !== '0) ns++;
        end
        nvec++;
        if (ns != 0 || err_val !== 18'h00400) begin
            nerr++;
            $display("FAIL gl_drop: got %0d strobes val=%h want 0 val=00400",
                     ns, err_val);
        end
        err_raw[3] = 1'b1;
        tick();
        tick();
        tick();
        nvec++;
        if (send_err !== 18'h00008 || err_val !== 18'h00408) begin
            nerr++;
            $display("FAIL gl_set: got send=%h val=%h want 00008/00408",
                     send_err, err_val);
        end
        err_raw[3] = 1'b0;
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h00008 || n != 6 || err_val !== 18'h00400) begin
            nerr++;
            $display("FAIL gl_clr: got %h after %0d val=%h want 00008/6/00400",
                     s, n, err_val);
        end
    endtask

    task automatic test_clear();
        logic [NCH-1:0] s;
        int n;
        apply_reset();
        err_raw[7] = 1'b1;
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h00080 || err_val !== 18'h00080) begin
            nerr++;
            $display("FAIL clr_setup: got %h val=%h want 00080", s, err_val);
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h3FFFF || n != 5 || err_val !== '0) begin
            nerr++;
            $display("FAIL clr_strobe: got %h after %0d val=%h want 3ffff/5/0",
                     s, n, err_val);
        end
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h00080 || n != 6 || err_val !== 18'h00080) begin
            nerr++;
            $display("FAIL clr_rerep: got %h after %0d val=%h want 00080/6/00080",
                     s, n, err_val);
        end
    endtask

    task automatic test_chan_en();
        logic [NCH-1:0] s;
        int n;
        int ns;
        apply_reset();
        chan_en[9] = 1'b0;
        err_raw[9] = 1'b1;
        ns = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (send_err !== '0) ns++;
        end
        nvec++;
        if (ns != 0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL en_mask: got %0d strobes busy=%b want 0/0", ns, busy);
        end
        chan_en[9] = 1'b1;
        wait_send(10, s, n);
        nvec++;
        if (s !== 18'h00200 || n != 3 || err_val !== 18'h00200) begin
            nerr++;
            $display("FAIL en_restore: got %h after %0d val=%h want 00200/3",
                     s, n, err_val);
        end
        #2;
        reset = 1'b0;
        #1;
        nvec++;
        if (send_err !== '0 || err_val !== '0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL async_rst: got send=%h val=%h busy=%b want 0",
                     send_err, err_val, busy);
        end
        tick();
        reset = 1'b1;
    endtask

`ifdef ERR_SCHED_CNT_EN
    task automatic test_counter();
        logic [NCH-1:0] s;
        int n;
        int bad;
        apply_reset();
        cnt_sel = 5'd1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            err_raw[1] = 1'b1;
            wait_send(14, s, n);
            if (s !== 18'h00002) bad++;
            err_raw[1] = 1'b0;
            wait_send(14, s, n);
            if (s !== 18'h00002) bad++;
            if (i == 2) begin
                tick();
                tick();
                nvec++;
                if (cnt_out !== 8'd3) begin
                    nerr++;
                    $display("FAIL cnt_three: got %0d want 3", cnt_out);
                end
            end
        end
        nvec++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL cnt_strobes: got %0d bad want 0", bad);
        end
        tick();
        tick();
        nvec++;
        if (cnt_out !== 8'd255) begin
            nerr++;
            $display("FAIL cnt_sat: got %0d want 255", cnt_out);
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_send(14, s, n);
        tick();
        nvec++;
        if (s !== 18'h3FFFF || cnt_out !== 8'd0) begin
            nerr++;
            $display("FAIL cnt_clear: got send=%h cnt=%0d want 3ffff/0",
                     s, cnt_out);
        end
    endtask
`endif

    initial begin
        reset     = 1'b0;
        err_raw   = '0;
        chan_en   = '1;
        clear_req = 1'b0;
`ifdef ERR_SCHED_CNT_EN
        cnt_sel   = '0;
`endif
        test_reset();
        test_round_robin();
        test_glitch();
        test_clear();
        test_chan_en();
`ifdef ERR_SCHED_CNT_EN
        test_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/err_report_sched.md
Name: err_report_sched

Overview:
- Scheduler that drives the per-channel error output register (its err_in/send_err inputs) for the NCH front-end error channels.
- Tracks which channel's raw error flag differs from the last value reported, and issues one-hot update strobes round-robin.
- Enforces a holdoff between updates so the downstream status link is not flooded.
- Provides a clear-all sequence.

Parameters:
- NCH, 18, number of error channels.
- HOLDOFF, 4, idle cycles after each update strobe (0 allowed).
- HW, 8, width of the holdoff counter; HOLDOFF must be < 2^HW.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- err_raw  in  NCH  raw per-channel error flags, synchronous to clk.
- chan_en  in  NCH  per-channel report enable; 0 masks the channel.
- clear_req  in  1  single-cycle pulse requesting a clear-all.
- err_val  out  NCH  registered error values; connects to err_in of the output register.
- send_err  out  NCH  registered update strobes; connects to send_err of the output register.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release) clears:
  - err_val, send_err, busy: 0.
  - reported[NCH-1:0]: 0.
  - ptr: 0.
  - clr_pend: 0.
  - holdoff counter: 0.
  - FSM: IDLE.
- reported is the internal copy of the last value sent per channel.
- pending[i] = chan_en[i] & (err_raw[i] != reported[i]). It is registered, so it is valid one cycle after err_raw changes.
- clr_pend is set by clear_req in any state. It is cleared on entry to CLEAR.
- Winner selection: the first set pending bit searching upward from ptr, wrapping from NCH-1 to 0.
- IDLE:
  - clr_pend=1 -> CLEAR. Clear has priority over pending.
  - Else any pending -> ISSUE; latch winner index w.
  - Else stay in IDLE.
- ISSUE (exactly 1 cycle):
  - send_err = one-hot(w); err_val[w] = err_raw[w] (current sample); other err_val bits are held.
  - reported[w] <= err_raw[w].
  - ptr <= (w == NCH-1) ? 0 : w+1.
  - Next state: HOLD if HOLDOFF > 0, else IDLE.
- CLEAR (exactly 1 cycle):
  - send_err = all ones; err_val = all zeros; reported <= 0; ptr unchanged.
  - Next state: HOLD if HOLDOFF > 0, else IDLE.
  - Active errors become pending again afterwards and are re-reported.
- HOLD:
  - Counter loads HOLDOFF on entry and decrements each cycle.
  - Returns to IDLE when the counter reaches 1, so HOLD lasts HOLDOFF cycles.
  - send_err = 0.
- send_err is 0 in every state except ISSUE and CLEAR.
- Latency: err_raw edge sampled at clock k -> send_err high from edge k+2 to edge k+3, provided the FSM is IDLE and no other channel is pending.
- Update spacing: at most one strobe every HOLDOFF+2 cycles per FSM pass.
- Channel toggling while its update is in flight: handled by the reported mismatch. A flag that returns to its old value before ISSUE is dropped, not reported.
- chan_en cleared while pending: the channel is dropped and its reported value is held. Re-enabling re-evaluates the mismatch.
- clear_req during ISSUE/HOLD: serviced at the next IDLE, before any pending channel.
- Reset mid-operation: all state is reinitialised immediately; any strobe in progress aborts.

Optional Feature:
- Macro: ERR_SCHED_CNT_EN.
- When defined, adds:
  - Per-channel 8-bit saturating counters of reported 0->1 transitions; they increment in ISSUE when err_raw[w]=1 and reported[w]=0.
  - Input cnt_sel [$clog2(NCH)-1:0].
  - Output cnt_out [7:0], registered: cnt_out = count[cnt_sel] one cycle after cnt_sel.
  - CLEAR zeroes all counters. Reset zeroes all counters and cnt_out.
  - Counters saturate at 255.
- When undefined: no counters and no cnt_sel/cnt_out ports. Behaviour is otherwise identical.

Test Plan:
- Reset with err_raw=0x00004, chan_en=all ones: first strobe send_err=0x00004, err_val[2]=1 at edge 3 after release; busy high for 1+HOLDOFF cycles.
- Set err_raw bits 0, 5, 17 in the same cycle, HOLDOFF=4: strobes 0x00001, 0x00020, 0x20000 in that order, 6 cycles apart; ptr wraps to 0.
- Set err_raw[3] high for exactly 1 cycle while the FSM is in HOLD: no strobe for channel 3 (mismatch gone); a 3-cycle pulse yields set then clear strobes.
- Pulse clear_req during HOLD with err_raw[7]=1: CLEAR strobe send_err=0x3FFFF, err_val=0 at the next IDLE, then re-report send_err=0x00080, err_val[7]=1.
- Set chan_en[9]=0 and toggle err_raw[9]: no strobe; restore chan_en[9]=1 -> strobe for bit 9 within 2 cycles. Assert reset mid-HOLD -> all outputs 0 asynchronously.
- With ERR_SCHED_CNT_EN: 300 rise/fall cycles on channel 1 -> cnt_out=255 with cnt_sel=1; after clear_req -> 0.
